dcache_ctrl: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache between the EX/MEM pipeline register and the backing data memory.
- Serves loads and stores from the MEM stage and raises a stall on a miss.
- On a miss it writes back a dirty victim line and refills the line through a req/ack handshake.
- Replaces the single-cycle data memory path in the CPU top.

---
 rtl/dcache_pkg.sv | 44 ++++
 rtl/dcache_array.sv | 77 +++++++
 rtl/dcache_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : dcache_pkg                                                      |
// | Brief  : Shared types, field-width constants and address-split helpers  |
// |          for the direct-mapped write-back data cache.                    |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
package dcache_pkg;

    // Default geometry; modules recompute their own widths from parameters.
    localparam int c_NUM_LINES  = 16;
    localparam int c_LINE_WORDS = 4;
    localparam int c_ADDR_W     = 32;

    localparam int OFF    = $clog2(c_LINE_WORDS);
    localparam int IDX    = $clog2(c_NUM_LINES);
    localparam int TAG_W  = c_ADDR_W - IDX - OFF - 2;
    localparam int LINE_W = 32 * c_LINE_WORDS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WB    = 2'd1,
        ST_ALLOC = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Helpers work on a zero-extended 64-bit address so they serve any
    // address width; callers slice the low bits they need.
    function automatic logic [63:0] addr_word(input logic [63:0] addr, input int off);
        return (addr >> 2) & ((64'd1 << off) - 64'd1);
    endfunction

    function automatic logic [63:0] addr_index(input logic [63:0] addr, input int off,
                                               input int idx);
        return (addr >> (off + 2)) & ((64'd1 << idx) - 64'd1);
    endfunction

    function automatic logic [63:0] addr_tag(input logic [63:0] addr, input int off,
                                             input int idx);
        return addr >> (off + idx + 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_array.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : dcache_array                                                    |
// | Brief  : Valid/dirty/tag/data storage for the direct-mapped cache.       |
// |          Combinational read port, one synchronous write port.           |
// | Rev    : 1.0  initial release                                            |
// | Ports  : clk, rst (sync, active-high: clears valid/dirty)                |
// |          i_rd_idx -> o_rd_valid/o_rd_dirty/o_rd_tag/o_rd_line            |
// |          i_wr_line_en : whole-line fill (valid=1, dirty=0, tag updated)  |
// |          i_wr_word_en : single-word store (dirty=1)                      |
// +--------------------------------------------------------------------------+
module dcache_array
    import dcache_pkg::*;
#(
    parameter int NUM_LINES  = dcache_pkg::c_NUM_LINES,
    parameter int LINE_WORDS = dcache_pkg::c_LINE_WORDS,
    parameter int TAG_W      = dcache_pkg::TAG_W
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [$clog2(NUM_LINES)-1:0]   i_rd_idx,
    output logic                           o_rd_valid,
    output logic                           o_rd_dirty,
    output logic [TAG_W-1:0]               o_rd_tag,
    output logic [32*LINE_WORDS-1:0]       o_rd_line,
    input  logic                           i_wr_line_en,
    input  logic                           i_wr_word_en,
    input  logic [$clog2(NUM_LINES)-1:0]   i_wr_idx,
    input  logic [$clog2(LINE_WORDS)-1:0]  i_wr_word,
    input  logic [31:0]                    i_wr_wdata,
    input  logic [32*LINE_WORDS-1:0]       i_wr_line,
    input  logic [TAG_W-1:0]               i_wr_tag
);

    localparam int c_OFF    = $clog2(LINE_WORDS);
    localparam int c_LINE_W = 32 * LINE_WORDS;

    logic [NUM_LINES-1:0] r_valid;
    logic [NUM_LINES-1:0] r_dirty;
    logic [TAG_W-1:0]     r_tag  [NUM_LINES];
    logic [c_LINE_W-1:0]  r_data [NUM_LINES];

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_dirty = r_dirty[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_line  = r_data[i_rd_idx];

    // Status bits are the only state that must be reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_wr_line_en) begin
            r_valid[i_wr_idx] <= 1'b1;
            r_dirty[i_wr_idx] <= 1'b0;
        end else if (i_wr_word_en) begin
            r_dirty[i_wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (i_wr_line_en) begin
                r_tag[i_wr_idx]  <= i_wr_tag;
                r_data[i_wr_idx] <= i_wr_line;
            end else if (i_wr_word_en) begin
                for (int i = 0; i < LINE_WORDS; i++) begin
                    if (i_wr_word == c_OFF'(i)) begin
                        r_data[i_wr_idx][i*32 +: 32] <= i_wr_wdata;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dcache_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : dcache_ctrl                                                     |
// | Brief  : Direct-mapped, write-back, write-allocate data cache for the    |
// |          MEM stage. Hits complete with no stall; misses write back a     |
// |          dirty victim, refill over a req/ack handshake, then replay.     |
// | Rev    : 1.0  initial release                                            |
// | Ports  : clk_i, rst_i (sync, active-low)                                 |
// |          cpu_req_i/cpu_we_i/cpu_addr_i/cpu_wdata_i -> cpu_rdata_o,       |
// |          cpu_stall_o                                                     |
// |          mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o (registered),         |
// |          mem_rdata_i, mem_ack_i (one-cycle completion pulse)             |
// +--------------------------------------------------------------------------+
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int NUM_LINES  = dcache_pkg::c_NUM_LINES,
    parameter int LINE_WORDS = dcache_pkg::c_LINE_WORDS,
    parameter int ADDR_W     = dcache_pkg::c_ADDR_W
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      cpu_req_i,
    input  logic                      cpu_we_i,
    input  logic [ADDR_W-1:0]         cpu_addr_i,
    input  logic [31:0]               cpu_wdata_i,
    output logic [31:0]               cpu_rdata_o,
    output logic                      cpu_stall_o,
    output logic                      mem_req_o,
    output logic                      mem_we_o,
    output logic [ADDR_W-1:0]         mem_addr_o,
    output logic [32*LINE_WORDS-1:0]  mem_wdata_o,
    input  logic [32*LINE_WORDS-1:0]  mem_rdata_i,
    input  logic                      mem_ack_i
);

    localparam int c_OFF    = $clog2(LINE_WORDS);
    localparam int c_IDX    = $clog2(NUM_LINES);
    localparam int c_TAG_W  = ADDR_W - c_IDX - c_OFF - 2;
    localparam int c_LINE_W = 32 * LINE_WORDS;

    // ---------------- address split ----------------
    logic [63:0]        w_addr64;
    logic [63:0]        w_word64;
    logic [63:0]        w_idx64;
    logic [63:0]        w_tag64;
    logic [c_OFF-1:0]   w_word;
    logic [c_IDX-1:0]   w_idx;
    logic [c_TAG_W-1:0] w_tag;
    logic               w_unused;

    always_comb begin
        w_addr64 = '0;
        w_addr64[ADDR_W-1:0] = cpu_addr_i;
    end

    assign w_word64 = addr_word(w_addr64, c_OFF);
    assign w_idx64  = addr_index(w_addr64, c_OFF, c_IDX);
    assign w_tag64  = addr_tag(w_addr64, c_OFF, c_IDX);
    assign w_word   = w_word64[c_OFF-1:0];
    assign w_idx    = w_idx64[c_IDX-1:0];
    assign w_tag    = w_tag64[c_TAG_W-1:0];
    assign w_unused = ^{w_word64[63:c_OFF], w_idx64[63:c_IDX], w_tag64[63:c_TAG_W]};

    // ---------------- storage ----------------
    logic                w_rd_valid;
    logic                w_rd_dirty;
    logic [c_TAG_W-1:0]  w_rd_tag;
    logic [c_LINE_W-1:0] w_rd_line;
    logic                w_wr_line_en;
    logic                w_wr_word_en;

    // ---------------- state / registered memory interface ----------------
    state_t              r_state;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [c_LINE_W-1:0] r_mem_wdata;

    logic                w_hit;
    logic                w_serve;
    logic [31:0]         w_word_data;

    assign w_hit = w_rd_valid && (w_rd_tag == w_tag);

    // An access is served either directly from IDLE or as the replay in DONE,
    // where the freshly filled line guarantees a hit.
    assign w_serve = cpu_req_i && w_hit &&
                     ((r_state == ST_IDLE) || (r_state == ST_DONE));

    always_comb begin
        w_word_data = '0;
        for (int i = 0; i < LINE_WORDS; i++) begin
            if (w_word == c_OFF'(i)) begin
                w_word_data = w_rd_line[i*32 +: 32];
            end
        end
    end

    assign cpu_rdata_o = (rst_i && w_serve && !cpu_we_i) ? w_word_data : 32'd0;

    // Stall comes up combinationally on the detecting cycle and drops in DONE.
    assign cpu_stall_o = rst_i && cpu_req_i &&
                         ((r_state == ST_WB) || (r_state == ST_ALLOC) ||
                          ((r_state == ST_IDLE) && !w_hit));

    assign w_wr_word_en = rst_i && w_serve && cpu_we_i;
    // Acks are only honoured while a request is outstanding.
    assign w_wr_line_en = rst_i && (r_state == ST_ALLOC) && r_mem_req && mem_ack_i;

    assign mem_req_o   = r_mem_req;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;

    dcache_array #(
        .NUM_LINES  (NUM_LINES),
        .LINE_WORDS (LINE_WORDS),
        .TAG_W      (c_TAG_W)
    ) u_array (
        .clk          (clk_i),
        .rst          (!rst_i),
        .i_rd_idx     (w_idx),
        .o_rd_valid   (w_rd_valid),
        .o_rd_dirty   (w_rd_dirty),
        .o_rd_tag     (w_rd_tag),
        .o_rd_line    (w_rd_line),
        .i_wr_line_en (w_wr_line_en),
        .i_wr_word_en (w_wr_word_en),
        .i_wr_idx     (w_idx),
        .i_wr_word    (w_word),
        .i_wr_wdata   (cpu_wdata_i),
        .i_wr_line    (mem_rdata_i),
        .i_wr_tag     (w_tag)
    );

    // The CPU holds its request stable while stalled, so the live address
    // fields are reused for the fill and the replay.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state     <= ST_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cpu_req_i && !w_hit) begin
                        r_mem_req <= 1'b1;
                        if (w_rd_valid && w_rd_dirty) begin
                            r_state     <= ST_WB;
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= {w_rd_tag, w_idx, {(c_OFF+2){1'b0}}};
                            r_mem_wdata <= w_rd_line;
                        end else begin
                            r_state    <= ST_ALLOC;
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= {w_tag, w_idx, {(c_OFF+2){1'b0}}};
                        end
                    end
                end
                ST_WB: begin
                    // Request drops for one cycle after the write-back ack;
                    // ALLOC raises the fetch on its first cycle.
                    if (mem_ack_i) begin
                        r_state   <= ST_ALLOC;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                    end
                end
                ST_ALLOC: begin
                    if (!r_mem_req) begin
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= {w_tag, w_idx, {(c_OFF+2){1'b0}}};
                    end else if (mem_ack_i) begin
                        r_state   <= ST_DONE;
                        r_mem_req <= 1'b0;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_dcache_ctrl                                                  |
// | Brief  : Scoreboard bench for dcache_ctrl with a latency-programmable    |
// |          backing-memory model and directed access vectors.               |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tb_dcache_ctrl;

    logic         clk_i;
    logic         rst_i;
    logic         cpu_req_i;
    logic         cpu_we_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_wdata_i;
    logic [31:0]  cpu_rdata_o;
    logic         cpu_stall_o;
    logic         mem_req_o;
    logic         mem_we_o;
    logic [31:0]  mem_addr_o;
    logic [127:0] mem_wdata_o;
    logic [127:0] mem_rdata_i;
    logic         mem_ack_i;

    dcache_ctrl #(
        .NUM_LINES  (16),
        .LINE_WORDS (4),
        .ADDR_W     (32)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cpu_req_i   (cpu_req_i),
        .cpu_we_i    (cpu_we_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_wdata_i (cpu_wdata_i),
        .cpu_rdata_o (cpu_rdata_o),
        .cpu_stall_o (cpu_stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          is_load;
        logic [31:0] rdata;
        int          stalls;
    } cpu_exp_t;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        int          widx;
        logic [31:0] wword;
    } mem_exp_t;

    cpu_exp_t     cpu_q[$];
    mem_exp_t     mem_q[$];
    logic [127:0] mem_model [logic [31:0]];
    int           n_pass  = 0;
    int           n_total = 0;
    int           lat     = 3;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic push_mem(input bit we, input logic [31:0] a, input int widx,
                            input logic [31:0] wword);
        mem_exp_t m;
        m.we = we; m.addr = a; m.widx = widx; m.wword = wword;
        mem_q.push_back(m);
    endtask

    // Called one time unit after a rising edge; returns likewise.
    task automatic access(input bit we, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] er, input int es);
        cpu_exp_t e;
        int n;
        e.is_load = !we; e.rdata = er; e.stalls = es;
        cpu_q.push_back(e);
        cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = a; cpu_wdata_i = d;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (cpu_stall_o && n < 200);
        chk("access_completes", cpu_stall_o, 1'b0);
        @(posedge clk_i); #1;
        cpu_req_i = 1'b0; cpu_we_i = 1'b0;
    endtask

    // Backing memory: ack after the request has been seen for lat cycles.
    initial begin
        int mcnt;
        mcnt = 0;
        mem_ack_i = 1'b0;
        mem_rdata_i = '0;
        forever begin
            @(posedge clk_i); #1;
            if (mem_ack_i) begin
                mem_ack_i = 1'b0;
                mcnt = 0;
            end else if (mem_req_o === 1'b1) begin
                mcnt++;
                if (mcnt > lat) begin
                    mem_ack_i = 1'b1;
                    if (mem_we_o)
                        mem_model[mem_addr_o] = mem_wdata_o;
                    else
                        mem_rdata_i = mem_model.exists(mem_addr_o) ? mem_model[mem_addr_o] : '0;
                end
            end else begin
                mcnt = 0;
            end
        end
    end

    // Monitor: pops expectations when the DUT completes a CPU access or starts
    // a memory request; also tracks request stability until ack.
    initial begin
        bit           prev_req;
        bit           unstable;
        int           stall_cnt;
        logic         cap_we;
        logic [31:0]  cap_addr;
        logic [127:0] cap_wd;
        cpu_exp_t     e;
        mem_exp_t     m;
        prev_req = 1'b0; unstable = 1'b0; stall_cnt = 0;
        cap_we = 1'b0; cap_addr = '0; cap_wd = '0;
        forever begin
            @(negedge clk_i);
            if (rst_i !== 1'b1) begin
                stall_cnt = 0;
            end else begin
                if (cpu_req_i) begin
                    if (cpu_stall_o) begin
                        stall_cnt++;
                    end else begin
                        chk("cpu_accept_expected", (cpu_q.size() != 0), 1'b1);
                        if (cpu_q.size() != 0) begin
                            e = cpu_q.pop_front();
                            if (e.is_load) chk("load_rdata", cpu_rdata_o, e.rdata);
                            chk("stall_cycles", stall_cnt, e.stalls);
                        end
                        stall_cnt = 0;
                    end
                end
                if (mem_req_o && !prev_req) begin
                    chk("mem_req_expected", (mem_q.size() != 0), 1'b1);
                    if (mem_q.size() != 0) begin
                        m = mem_q.pop_front();
                        chk("mem_we", mem_we_o, m.we);
                        chk("mem_addr", mem_addr_o, m.addr);
                        if (m.we) chk("wb_word", mem_wdata_o[m.widx*32 +: 32], m.wword);
                    end
                    cap_we = mem_we_o; cap_addr = mem_addr_o; cap_wd = mem_wdata_o;
                    unstable = !cpu_stall_o;
                end else if (mem_req_o) begin
                    if (mem_we_o !== cap_we || mem_addr_o !== cap_addr ||
                        mem_wdata_o !== cap_wd || cpu_stall_o !== 1'b1)
                        unstable = 1'b1;
                end
                if (mem_req_o && mem_ack_i) chk("req_stable_until_ack", unstable, 1'b0);
            end
            prev_req = mem_req_o;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: run did not finish, required finish before 400000");
        $fatal(1);
    end

    initial begin
        rst_i = 1'b0; cpu_req_i = 1'b0; cpu_we_i = 1'b0;
        cpu_addr_i = '0; cpu_wdata_i = '0;
        mem_model[32'h20]  = {32'd4, 32'd3, 32'd2, 32'd1};
        mem_model[32'h120] = {32'h14, 32'h13, 32'h12, 32'h11};
        mem_model[32'h0]   = {32'hD, 32'hC, 32'hB, 32'hA};
        mem_model[32'h1C0] = {32'h44, 32'h33, 32'h22, 32'h11};

        // Reset state
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_mem_req", mem_req_o, 1'b0);
        chk("rst_mem_we", mem_we_o, 1'b0);
        chk("rst_mem_addr", mem_addr_o, 32'd0);
        chk("rst_mem_wdata", mem_wdata_o, 128'd0);
        chk("rst_stall", cpu_stall_o, 1'b0);
        chk("rst_rdata", cpu_rdata_o, 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;

        // 1: cold load miss, then hit in the same line
        push_mem(1'b0, 32'h20, 0, 32'd0);
        access(1'b0, 32'h20, 32'd0, 32'd1, 5);
        access(1'b0, 32'h2C, 32'd0, 32'd4, 0);

        // 2: store hit then load back
        access(1'b1, 32'h24, 32'd99, 32'd0, 0);
        access(1'b0, 32'h24, 32'd0, 32'd99, 0);

        // 3: conflict miss on a dirty line
        push_mem(1'b1, 32'h20, 1, 32'd99);
        push_mem(1'b0, 32'h120, 0, 32'd0);
        access(1'b0, 32'h120, 32'd0, 32'h11, 10);
        chk("mem_0x20_word1", mem_model[32'h20][63:32], 32'd99);

        // 4: store miss on an invalid line, then evict it
        push_mem(1'b0, 32'h300, 0, 32'd0);
        access(1'b1, 32'h300, 32'd7, 32'd0, 5);
        push_mem(1'b1, 32'h300, 0, 32'd7);
        push_mem(1'b0, 32'h000, 0, 32'd0);
        access(1'b0, 32'h000, 32'd0, 32'hA, 10);
        chk("mem_0x300_word0", mem_model[32'h300][31:0], 32'd7);

        // 5: reset during write-back
        access(1'b1, 32'h120, 32'd5, 32'd0, 0);
        push_mem(1'b1, 32'h120, 0, 32'd5);
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h20;
        @(posedge clk_i);
        @(posedge clk_i); #1;
        chk("wb_in_progress", mem_req_o, 1'b1);
        rst_i = 1'b0; cpu_req_i = 1'b0;
        @(posedge clk_i); #1;
        chk("reset_drops_req", mem_req_o, 1'b0);
        rst_i = 1'b1;
        #1;
        chk("reset_drops_stall", cpu_stall_o, 1'b0);
        @(posedge clk_i); #1;
        push_mem(1'b0, 32'h20, 0, 32'd0);
        access(1'b0, 32'h20, 32'd0, 32'd1, 5);

        // 6: slow memory, 20 cycles without ack
        lat = 20;
        push_mem(1'b0, 32'h1C0, 0, 32'd0);
        access(1'b0, 32'h1C8, 32'd0, 32'h33, 22);
        lat = 3;
        access(1'b0, 32'h1C4, 32'd0, 32'h22, 0);

        repeat (5) @(posedge clk_i);
        chk("cpu_q_drained", cpu_q.size(), 0);
        chk("mem_q_drained", mem_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
